// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared constants and helpers for the parking-lot display
//               clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

   // Board oscillator frequency; the defaults below assume this clock.
   localparam int CLK_HZ        = 50000000;

   // 50 MHz / (2 * 25000) = 1 kHz digit scan clock.
   localparam int SCAN_HALF_DEF = 25000;

   // 50 MHz / (2 * 25000000) = 1 Hz "FULL" sequence clock.
   localparam int FULL_HALF_DEF = 25000000;

   // Counter width for a half-period of 'half' cycles: max(1, clog2(half)).
   function automatic int cnt_width(input int half);
      return (half > 1) ? $clog2(half) : 1;
   endfunction

endpackage : display_pkg
`default_nettype wire

// File: rtl/clk_div_core.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_core
// Description : Free-running divide-by-(2*HALF) clock with a registered
//               one-cycle tick on every rising edge of the divided clock.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_core
   import display_pkg::*;
#(
   parameter int HALF = 1
) (
   input  logic CLK,
   input  logic RST,
   output logic clk_out,
   output logic tick
);

   localparam int                 c_CNT_W = cnt_width(HALF);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(HALF - 1);
   localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

   // A half-period shorter than one cycle has no meaning; stop elaboration.
   generate
      if (HALF < 1) begin : g_half_check
         $error("clk_div_core: HALF must be >= 1");
      end
   endgenerate

   logic [c_CNT_W-1:0] cnt_q, cnt_d;
   logic               clk_q, clk_d;
   logic               tick_q, tick_d;
   logic               w_wrap;

   // Next-state: wrap the counter at HALF-1, toggle the output there, and
   // flag a tick only when that toggle takes the output from 0 to 1.
   always_comb begin
      w_wrap = (cnt_q == c_LAST);
      cnt_d  = w_wrap ? '0 : (cnt_q + c_ONE);
      clk_d  = clk_q ^ w_wrap;
      tick_d = w_wrap & ~clk_q;
   end

   // State registers; reset clears everything immediately.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q  <= '0;
         clk_q  <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
      end
   end

   assign clk_out = clk_q;
   assign tick    = tick_q;

endmodule : clk_div_core
`default_nettype wire

// File: rtl/display_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : display_clock_divider
// Description : Scan and "FULL" clock dividers for the seven-segment display,
//               with matching enable ticks and a lot-full tick select.
// Revision    : 1.0 - initial release
// ============================================================================
module display_clock_divider
   import display_pkg::*;
#(
   parameter int SCAN_HALF = SCAN_HALF_DEF,
   parameter int FULL_HALF = FULL_HALF_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic full,
   output logic scan_clk,
   output logic full_clk,
   output logic scan_tick,
   output logic full_tick,
   output logic sel_tick
);

   clk_div_core #(
      .HALF (SCAN_HALF)
   ) u_scan_div (
      .CLK     (CLK),
      .RST     (RST),
      .clk_out (scan_clk),
      .tick    (scan_tick)
   );

   clk_div_core #(
      .HALF (FULL_HALF)
   ) u_full_div (
      .CLK     (CLK),
      .RST     (RST),
      .clk_out (full_clk),
      .tick    (full_tick)
   );

   // Plain select of two registered ticks; downstream uses it as an enable,
   // so no clock muxing happens here.
   assign sel_tick = full ? full_tick : scan_tick;

endmodule : display_clock_divider
`default_nettype wire

// File: tb/tb_display_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_clock_divider
// Description : Randomized self-checking bench for display_clock_divider
//               against an edge-count arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_clock_divider;

   localparam int A_SCAN = 2;
   localparam int A_FULL = 5;
   localparam int B_SCAN = 1;
   localparam int B_FULL = 3;

   logic CLK;
   logic RST;
   logic full;

   logic a_scan_clk, a_full_clk, a_scan_tick, a_full_tick, a_sel_tick;
   logic b_scan_clk, b_full_clk, b_scan_tick, b_full_tick, b_sel_tick;

   int n;
   int errors;
   int checks;
   int cnt_a;
   int cnt_b;
   int cnt_h;

   display_clock_divider #(
      .SCAN_HALF (A_SCAN),
      .FULL_HALF (A_FULL)
   ) u_dut_a (
      .CLK       (CLK),
      .RST       (RST),
      .full      (full),
      .scan_clk  (a_scan_clk),
      .full_clk  (a_full_clk),
      .scan_tick (a_scan_tick),
      .full_tick (a_full_tick),
      .sel_tick  (a_sel_tick)
   );

   display_clock_divider #(
      .SCAN_HALF (B_SCAN),
      .FULL_HALF (B_FULL)
   ) u_dut_b (
      .CLK       (CLK),
      .RST       (RST),
      .full      (full),
      .scan_clk  (b_scan_clk),
      .full_clk  (b_full_clk),
      .scan_tick (b_scan_tick),
      .full_tick (b_full_tick),
      .sel_tick  (b_sel_tick)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Reference: after k rising edges since reset release, the divided clock
   // has completed k/half half-periods, and a tick follows each edge on which
   // an odd half-period count is first reached.
   function automatic logic exp_clk(input int k, input int half);
      return ((k / half) % 2) == 1;
   endfunction

   function automatic logic exp_tick(input int k, input int half);
      return (k > 0) && ((k % (2 * half)) == half);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check($sformatf("%s a_scan_clk n=%0d", tag, n),  32'(a_scan_clk),  32'(exp_clk(n, A_SCAN)));
      check($sformatf("%s a_full_clk n=%0d", tag, n),  32'(a_full_clk),  32'(exp_clk(n, A_FULL)));
      check($sformatf("%s a_scan_tick n=%0d", tag, n), 32'(a_scan_tick), 32'(exp_tick(n, A_SCAN)));
      check($sformatf("%s a_full_tick n=%0d", tag, n), 32'(a_full_tick), 32'(exp_tick(n, A_FULL)));
      check($sformatf("%s a_sel_tick n=%0d f=%0b", tag, n, full), 32'(a_sel_tick),
            32'(full ? exp_tick(n, A_FULL) : exp_tick(n, A_SCAN)));
      check($sformatf("%s b_scan_clk n=%0d", tag, n),  32'(b_scan_clk),  32'(exp_clk(n, B_SCAN)));
      check($sformatf("%s b_full_clk n=%0d", tag, n),  32'(b_full_clk),  32'(exp_clk(n, B_FULL)));
      check($sformatf("%s b_scan_tick n=%0d", tag, n), 32'(b_scan_tick), 32'(exp_tick(n, B_SCAN)));
      check($sformatf("%s b_full_tick n=%0d", tag, n), 32'(b_full_tick), 32'(exp_tick(n, B_FULL)));
      check($sformatf("%s b_sel_tick n=%0d f=%0b", tag, n, full), 32'(b_sel_tick),
            32'(full ? exp_tick(n, B_FULL) : exp_tick(n, B_SCAN)));
   endtask

   // One CLK edge: advance the model if out of reset, then sample 1 time unit later.
   task automatic step(input string tag);
      @(posedge CLK);
      if (!RST) n++;
      #1;
      check_all(tag);
   endtask

   initial begin
      int r;
      int k;
      errors = 0;
      checks = 0;
      n      = 0;
      RST    = 1'b1;
      full   = 1'b0;

      // Outputs held at zero while in reset, across several edges.
      repeat (3) step("rst");
      #3 RST = 1'b0;

      // Release: scan rises at edge 2, falls at 4, rises at 6; full rises at 5.
      repeat (8) step("run");
      check("pre_arst a_full_clk", 32'(a_full_clk), 32'd1);

      // Asynchronous reset mid-count: no edge in between.
      #3 RST = 1'b1;
      n = 0;
      #1 check_all("arst_imm");
      repeat (2) step("arst_hold");
      #3 RST = 1'b0;

      // Tick counting over 40 cycles after a fresh release.
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < 40; i++) begin
         step("tick40");
         cnt_a += int'(a_scan_tick);
         cnt_b += int'(b_scan_tick);
      end
      check("a_scan_tick count40", 32'(cnt_a), 32'd10);
      check("b_scan_tick count40", 32'(cnt_b), 32'd20);

      // Duty of the HALF=5 channel over 100 cycles.
      cnt_h = 0;
      cnt_a = 0;
      for (int i = 0; i < 100; i++) begin
         step("duty");
         cnt_h += int'(a_full_clk);
         cnt_a += int'(a_full_tick);
      end
      check("a_full_clk high100", 32'(cnt_h), 32'd50);
      check("a_full_tick count100", 32'(cnt_a), 32'd10);

      // Directed full select 0 -> 1 -> 0.
      #2 full = 1'b1;
      #1 check_all("sel_to1");
      repeat (12) step("sel1");
      #2 full = 1'b0;
      #1 check_all("sel_to0");
      repeat (12) step("sel0");

      // Randomized full toggles and asynchronous resets.
      for (int i = 0; i < 400; i++) begin
         step("rand");
         r = int'($urandom_range(0, 99));
         if (r < 15) begin
            #2 full = ~full;
            #1 check_all("rand_sel");
         end else if (r < 19) begin
            #3 RST = 1'b1;
            n = 0;
            #1 check_all("rand_arst");
            k = int'($urandom_range(1, 3));
            repeat (k) step("rand_hold");
            #3 RST = 1'b0;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_display_clock_divider
`default_nettype wire
